seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 6-digit common-anode seven-segment display. It accepts a 24-bit hex value, decimal points and per-digit enables through a request/acknowledge load handshake, and holds them in a shadow register updated only at frame boundaries so the display never tears. It sequences the shared segment bus across the six digits with a programmable slot time and anti-ghosting dead time. It replaces static driving of `seg_sel`/`seg_led` in the display top level, fed by the counting logic upstream.

---
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode seven-segment scan controller. Content is loaded into a
// shadow register at frame boundaries only, then scanned digit by digit with a dead time.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK_CYC = 500
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [23:0] data_in,
  input  logic [5:0]  dp_in,
  input  logic [5:0]  en_in,
  input  logic        lz_blank,
  input  logic        load_req,
  output logic        load_ack,
  output logic        frame_done,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [23:0]   data_sh, data_nxt;
  logic [5:0]    dp_sh, dp_nxt;
  logic [5:0]    en_sh, en_nxt;
  logic          lz_sh, lz_nxt;
  logic          boundary, take;
  logic [5:0]    sup;
  logic          lz_seen;
  logic [3:0]    nib;
  logic [7:0]    dec;
  logic [5:0]    sel_nxt;
  logic [7:0]    led_nxt;
  logic          fd_nxt;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 8'hC0;
      4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;
      4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;
      4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;
      4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;
      4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;
      4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  // Handshake: load_req is a level held by the requester; it is accepted only on the
  // cycle with idx=0,cnt=0, and load_ack pulses for exactly the following cycle.
  always_comb begin
    boundary = (cnt == '0) && (idx == 3'd0);
    take     = boundary && load_req;
    cnt_nxt  = cnt + 1'b1;
    idx_nxt  = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    data_nxt = take ? data_in  : data_sh;
    dp_nxt   = take ? dp_in    : dp_sh;
    en_nxt   = take ? en_in    : en_sh;
    lz_nxt   = take ? lz_blank : lz_sh;
  end

  // Leading-zero suppression: only an enabled nonzero digit ends the scan-down.
  always_comb begin
    sup     = '0;
    lz_seen = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (lz_nxt && !lz_seen && (i != 0) && (data_nxt[i*4 +: 4] == 4'd0))
        sup[i] = 1'b1;
      if (en_nxt[i] && (data_nxt[i*4 +: 4] != 4'd0))
        lz_seen = 1'b1;
    end
  end

  // Outputs are computed from next-cycle state so the registered pins line up with cnt/idx.
  always_comb begin
    nib     = data_nxt[{idx_nxt, 2'b00} +: 4];
    dec     = hex_to_seg(nib);
    sel_nxt = 6'h3F;
    led_nxt = 8'hFF;
    if ((cnt_nxt >= CNT_BLANK) && en_nxt[idx_nxt] && !sup[idx_nxt]) begin
      sel_nxt = 6'h3F & ~(6'b000001 << idx_nxt);
      led_nxt = {~dp_nxt[idx_nxt], dec[6:0]};
    end
    fd_nxt = (idx_nxt == 3'd5) && (cnt_nxt == CNT_LAST);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      data_sh    <= '0;
      dp_sh      <= '0;
      en_sh      <= '0;
      lz_sh      <= 1'b0;
      seg_sel    <= 6'h3F;
      seg_led    <= 8'hFF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      data_sh    <= data_nxt;
      dp_sh      <= dp_nxt;
      en_sh      <= en_nxt;
      lz_sh      <= lz_nxt;
      seg_sel    <= sel_nxt;
      seg_led    <= led_nxt;
      load_ack   <= take;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: expected per-slot display pushed to a queue and
// popped while the frame is scanned, with ack/frame_done checked every cycle.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam logic [13:0] DARK = {6'h3F, 8'hFF};

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [23:0] data_in = '0;
  logic [5:0]  dp_in   = '0;
  logic [5:0]  en_in   = '0;
  logic        lz_blank = 1'b0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic        frame_done;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  logic [13:0] exp_q[$];
  logic [23:0] pend_data;
  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .lz_blank   (lz_blank),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .seg_sel    (seg_sel),
    .seg_led    (seg_led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [13:0] d0, input logic [13:0] d1, input logic [13:0] d2,
                            input logic [13:0] d3, input logic [13:0] d4, input logic [13:0] d5);
    exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2);
    exp_q.push_back(d3); exp_q.push_back(d4); exp_q.push_back(d5);
  endtask

  task automatic push_dark;
    push_frame(DARK, DARK, DARK, DARK, DARK, DARK);
  endtask

  // Starts at the first cycle of a frame (idx=0,cnt=0), ends at the first cycle of the next.
  task automatic run_frame(input bit ack_exp, input int raise_slot);
    logic [13:0] e;
    for (int s = 0; s < 6; s++) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_empty observed=0 expected=1 at slot %0d", s);
        e = DARK;
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < SD; c++) begin
        if (s == raise_slot && c == 0) begin
          data_in  = pend_data;
          load_req = 1'b1;
        end
        chk($sformatf("disp_s%0d_c%0d", s, c), {seg_sel, seg_led}, (c < BC) ? DARK : e);
        chk($sformatf("ack_s%0d_c%0d", s, c), {13'd0, load_ack},
            {13'd0, (ack_exp && s == 0 && c == 1)});
        chk($sformatf("fdone_s%0d_c%0d", s, c), {13'd0, frame_done},
            {13'd0, (s == 5 && c == SD - 1)});
        if (load_ack) load_req = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_disp", {seg_sel, seg_led}, DARK);
    chk("rst_ack", {13'd0, load_ack}, 14'd0);
    chk("rst_fdone", {13'd0, frame_done}, 14'd0);
    sys_rst = 1'b0;

    // Two frames with nothing loaded
    push_dark();
    run_frame(1'b0, -1);
    push_dark();
    run_frame(1'b0, -1);

    // Plain load of 123456
    data_in = 24'h123456; en_in = 6'h3F; dp_in = 6'h00; lz_blank = 1'b0; load_req = 1'b1;
    push_frame({6'h3E, 8'h82}, {6'h3D, 8'h92}, {6'h3B, 8'h99},
               {6'h37, 8'hB0}, {6'h2F, 8'hA4}, {6'h1F, 8'hF9});
    run_frame(1'b1, -1);

    // Mid-frame request waits for the next boundary; current frame unchanged
    pend_data = 24'hABCDEF;
    push_frame({6'h3E, 8'h82}, {6'h3D, 8'h92}, {6'h3B, 8'h99},
               {6'h37, 8'hB0}, {6'h2F, 8'hA4}, {6'h1F, 8'hF9});
    run_frame(1'b0, 2);
    push_frame({6'h3E, 8'h8E}, {6'h3D, 8'h86}, {6'h3B, 8'hA1},
               {6'h37, 8'hC6}, {6'h2F, 8'h83}, {6'h1F, 8'h88});
    run_frame(1'b1, -1);

    // Leading-zero suppression
    data_in = 24'h000400; lz_blank = 1'b1; load_req = 1'b1;
    push_frame({6'h3E, 8'hC0}, {6'h3D, 8'hC0}, {6'h3B, 8'h99}, DARK, DARK, DARK);
    run_frame(1'b1, -1);
    data_in = 24'h000000; load_req = 1'b1;
    push_frame({6'h3E, 8'hC0}, DARK, DARK, DARK, DARK, DARK);
    run_frame(1'b1, -1);

    // Disabled nonzero digit 5 does not end the scan-down
    data_in = 24'h500400; en_in = 6'b011111; load_req = 1'b1;
    push_frame({6'h3E, 8'hC0}, {6'h3D, 8'hC0}, {6'h3B, 8'h99}, DARK, DARK, DARK);
    run_frame(1'b1, -1);

    // Decimal point, no suppression
    data_in = 24'h000400; en_in = 6'h3F; dp_in = 6'b000100; lz_blank = 1'b0; load_req = 1'b1;
    push_frame({6'h3E, 8'hC0}, {6'h3D, 8'hC0}, {6'h3B, 8'h19},
               {6'h37, 8'hC0}, {6'h2F, 8'hC0}, {6'h1F, 8'hC0});
    run_frame(1'b1, -1);

    // Reset during digit 3 SHOW, then display stays dark
    for (int k = 0; k < 3 * SD + 4; k++) tick();
    chk("pre_rst_disp", {seg_sel, seg_led}, {6'h37, 8'hC0});
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_disp", {seg_sel, seg_led}, DARK);
    chk("mid_rst_ack", {13'd0, load_ack}, 14'd0);
    chk("mid_rst_fdone", {13'd0, frame_done}, 14'd0);
    sys_rst = 1'b0;
    push_dark();
    run_frame(1'b0, -1);

    // Held request across reset release is served at the first boundary
    data_in = 24'h000009; en_in = 6'b000001; dp_in = 6'b000001; load_req = 1'b1;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    push_frame({6'h3E, 8'h10}, DARK, DARK, DARK, DARK, DARK);
    run_frame(1'b1, -1);

    chk("queue_drained", 14'(exp_q.size()), 14'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
